dmem_responder: RTL

//  Data-memory responder serving the pipeline's MEM-stage load/store requests.

---
 rtl/dmem_responder.sv | 73 +++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a multi-cycle request/stall handshake.
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              stall,
   output logic              err
);
   localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;
   stateT             state, nextState;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] capIdx;
   logic [DATA_W-1:0] capWdata;
   logic              capStore, capMis, capErr;
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic              req, access;
   logic              unusedAddr;

   assign req        = mem_read | mem_write;
   assign access     = state == WAIT && cnt == '0;
   assign unusedAddr = ^addr[31:ADDR_W+2];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nextState;

   always_comb
      nextState = state == IDLE ? (req ? WAIT : IDLE) :
                  state == WAIT ? (cnt == '0 ? DONE : WAIT) : IDLE;

   // Reset forces stall low even while the pipeline still presents a request.
   always_comb begin
      stall  = rst_n && ((state == IDLE && req) || state == WAIT);
      rvalid = state == DONE;
      err    = state == DONE && capErr;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt      <= '0;
         capIdx   <= '0;
         capWdata <= '0;
         capStore <= 1'b0;
         capMis   <= 1'b0;
         capErr   <= 1'b0;
      end else if (state == IDLE && req) begin
         cnt      <= CW'(LATENCY - 1);
         capIdx   <= addr[ADDR_W+1:2];
         capWdata <= wdata;
         capStore <= mem_write;
         capMis   <= addr[1:0] != 2'b00;
         capErr   <= addr[1:0] != 2'b00 || (mem_read && mem_write);
      end else if (state == WAIT && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end

   always_ff @(posedge clk)
      if (access && capStore && !capMis) ram[capIdx] <= capWdata;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                    rdata <= '0;
      else if (access && !capStore)  rdata <= capMis ? '0 : ram[capIdx];
endmodule
